program_counter_stage: RTL and testbench

//  PC stage: holds the fetch PC and selects the next PC each cycle. Sits upstream of the I-cache and IF

---
 rtl/program_counter_stage_pkg.sv | 33 +++
 rtl/program_counter_stage_if.sv | 32 +++
 rtl/program_counter_stage_branch_target_buffer.sv | 70 +++++++
 rtl/program_counter_stage.sv | 80 ++++++++
 tb/tb_program_counter_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_counter_stage_pkg.sv
// Shared pipeline definitions for the PC stage: default widths, reset vector and
// 2-bit branch counter encodings with their training function.
package program_counter_stage_pkg;

    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam logic [31:0] RESET_VECTOR  = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT  = 4;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_e;

    // Saturating move toward the observed direction.
    function automatic bp_ctr_e ctr_train(input bp_ctr_e ctr, input logic taken);
        bp_ctr_e nxt;
        nxt = ctr;
        case (ctr)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/program_counter_stage_if.sv
// Control/redirect/resolve bundle between the pipeline and the PC stage.
// master = pipeline side (hazard unit, execute), slave = PC stage.
interface program_counter_stage_if #(
    parameter int unsigned ADDRESS_WIDTH = program_counter_stage_pkg::ADDRESS_WIDTH
) ();

    logic                     STALL_PROGRAME_COUNTER_STAGE;
    logic                     PC_MISPREDICTED;
    logic [ADDRESS_WIDTH-1:0] REDIRECT_TARGET;
    logic                     BRANCH_RESOLVED;
    logic [ADDRESS_WIDTH-1:0] BRANCH_PC_EXECUTION;
    logic                     BRANCH_TAKEN_EXECUTION;
    logic [ADDRESS_WIDTH-1:0] BRANCH_TARGET_EXECUTION;
    logic [ADDRESS_WIDTH-1:0] PC;
    logic                     PC_PREDICTED_TAKEN;
    logic [ADDRESS_WIDTH-1:0] PC_PREDICTED_TARGET;

    modport master (
        output STALL_PROGRAME_COUNTER_STAGE, PC_MISPREDICTED, REDIRECT_TARGET,
               BRANCH_RESOLVED, BRANCH_PC_EXECUTION, BRANCH_TAKEN_EXECUTION,
               BRANCH_TARGET_EXECUTION,
        input  PC, PC_PREDICTED_TAKEN, PC_PREDICTED_TARGET
    );

    modport slave (
        input  STALL_PROGRAME_COUNTER_STAGE, PC_MISPREDICTED, REDIRECT_TARGET,
               BRANCH_RESOLVED, BRANCH_PC_EXECUTION, BRANCH_TAKEN_EXECUTION,
               BRANCH_TARGET_EXECUTION,
        output PC, PC_PREDICTED_TAKEN, PC_PREDICTED_TARGET
    );

endinterface

// File: rtl/program_counter_stage_branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup port,
// synchronous update port, async clear of valid bits and counters.
module program_counter_stage_branch_target_buffer
    import program_counter_stage_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned IDX_W = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] lookup_pc_i,
    output logic          pred_taken_o,
    output logic [AW-1:0] pred_target_o,
    input  logic          upd_valid_i,
    input  logic [AW-1:0] upd_pc_i,
    input  logic          upd_taken_i,
    input  logic [AW-1:0] upd_target_i
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = AW - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    bp_ctr_e          ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [AW-1:0]    target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[AW-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[AW-1:IDX_W+2];
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Arrays update on the clock edge, so a same-cycle lookup sees old contents.
    assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target_o = target_q[lk_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_W'(i)] <= LOW;
                ctr_q[IDX_W'(i)]   <= WEAK_NT;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_train(ctr_q[up_idx], upd_taken_i);
            end else if (upd_taken_i) begin
                valid_q[up_idx] <= HIGH;
                ctr_q[up_idx]   <= WEAK_T;
            end
        end
    end

    // Tag rewrite on a taken hit is a no-op; on a miss it allocates.
    always_ff @(posedge clk_i) begin
        if (upd_valid_i && upd_taken_i) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/program_counter_stage.sv
// Fetch PC register with stall-safe pending redirect and BTB-driven next-PC selection.
module program_counter_stage #(
    parameter int unsigned ADDRESS_WIDTH   = program_counter_stage_pkg::ADDRESS_WIDTH,
    parameter int unsigned BTB_INDEX_WIDTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR =
        ADDRESS_WIDTH'(program_counter_stage_pkg::RESET_VECTOR),
    parameter int unsigned PC_INCREMENT    = program_counter_stage_pkg::PC_INCREMENT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    program_counter_stage_if.slave  pcs
);

    import program_counter_stage_pkg::*;

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic                     pend_vld_q, pend_vld_d;
    logic                     btb_taken;
    logic [ADDRESS_WIDTH-1:0] btb_target;
    logic [ADDRESS_WIDTH-1:0] seq_pc;
    logic [ADDRESS_WIDTH-1:0] pred_target;

    program_counter_stage_branch_target_buffer #(
        .AW    (ADDRESS_WIDTH),
        .IDX_W (BTB_INDEX_WIDTH)
    ) u_btb (
        .clk_i         (CLK),
        .rst_ni        (RST_N),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (btb_taken),
        .pred_target_o (btb_target),
        .upd_valid_i   (pcs.BRANCH_RESOLVED),
        .upd_pc_i      (pcs.BRANCH_PC_EXECUTION),
        .upd_taken_i   (pcs.BRANCH_TAKEN_EXECUTION),
        .upd_target_i  (pcs.BRANCH_TARGET_EXECUTION)
    );

    assign seq_pc      = pc_q + ADDRESS_WIDTH'(PC_INCREMENT);
    assign pred_target = btb_taken ? btb_target : seq_pc;

    // A redirect arriving under stall is parked so it survives any stall length;
    // a newer redirect always replaces the parked one.
    always_comb begin
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        if (pcs.STALL_PROGRAME_COUNTER_STAGE) begin
            if (pcs.PC_MISPREDICTED) begin
                pend_tgt_d = pcs.REDIRECT_TARGET;
                pend_vld_d = HIGH;
            end
        end else if (pcs.PC_MISPREDICTED) begin
            pc_d       = pcs.REDIRECT_TARGET;
            pend_vld_d = LOW;
        end else if (pend_vld_q) begin
            pc_d       = pend_tgt_q;
            pend_vld_d = LOW;
        end else begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q       <= RESET_VECTOR;
            pend_tgt_q <= '0;
            pend_vld_q <= LOW;
        end else begin
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign pcs.PC                  = pc_q;
    assign pcs.PC_PREDICTED_TAKEN  = btb_taken;
    assign pcs.PC_PREDICTED_TARGET = pred_target;

endmodule

// File: tb/tb_program_counter_stage.sv
// Self-checking bench for program_counter_stage: directed vector table, multi-cycle
// BTB/reset sequences, and randomized traffic against a behavioural model.
module tb_program_counter_stage;

    logic CLK;
    logic RST_N;

    program_counter_stage_if #(.ADDRESS_WIDTH(32)) bus ();

    program_counter_stage #(
        .ADDRESS_WIDTH   (32),
        .BTB_INDEX_WIDTH (4),
        .RESET_VECTOR    (32'h0000_0000),
        .PC_INCREMENT    (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .pcs   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          v;
        logic [25:0] tag;
        logic [31:0] tgt;
        int          ctr;
    } m_ent_t;

    m_ent_t      mb [16];
    logic [31:0] m_pc;
    logic [31:0] m_pt;
    bit          m_pv;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            mb[i].v   = 1'b0;
            mb[i].ctr = 1;
            mb[i].tag = '0;
            mb[i].tgt = '0;
        end
        m_pc = 32'h0;
        m_pv = 1'b0;
        m_pt = 32'h0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] nxt);
        int idx;
        idx = int'((pc / 4) % 16);
        tk  = mb[idx].v && (mb[idx].tag == pc[31:6]) && (mb[idx].ctr >= 2);
        nxt = tk ? mb[idx].tgt : pc + 32'd4;
    endtask

    task automatic m_edge(input bit stall, input bit mis, input logic [31:0] rt,
                          input bit res, input logic [31:0] bpc, input bit btk,
                          input logic [31:0] btgt);
        bit          tk;
        logic [31:0] pred;
        logic [31:0] npc;
        int          idx;
        m_lookup(m_pc, tk, pred);
        npc = m_pc;
        if (stall) begin
            if (mis) begin
                m_pv = 1'b1;
                m_pt = rt;
            end
        end else if (mis) begin
            npc  = rt;
            m_pv = 1'b0;
        end else if (m_pv) begin
            npc  = m_pt;
            m_pv = 1'b0;
        end else begin
            npc = pred;
        end
        if (res) begin
            idx = int'((bpc / 4) % 16);
            if (mb[idx].v && mb[idx].tag == bpc[31:6]) begin
                mb[idx].ctr = btk ? ((mb[idx].ctr == 3) ? 3 : mb[idx].ctr + 1)
                                  : ((mb[idx].ctr == 0) ? 0 : mb[idx].ctr - 1);
                if (btk) mb[idx].tgt = btgt;
            end else if (btk) begin
                mb[idx].v   = 1'b1;
                mb[idx].tag = bpc[31:6];
                mb[idx].tgt = btgt;
                mb[idx].ctr = 2;
            end
        end
        m_pc = npc;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0)
            a = 32'hFFFF_FFF8 | (32'($urandom_range(0, 1)) << 2);
        else
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        return a;
    endfunction

    // ---------------- directed helpers ----------------
    task automatic idle_inputs();
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b0;
        bus.PC_MISPREDICTED              = 1'b0;
        bus.REDIRECT_TARGET              = '0;
        bus.BRANCH_RESOLVED              = 1'b0;
        bus.BRANCH_PC_EXECUTION          = '0;
        bus.BRANCH_TAKEN_EXECUTION       = 1'b0;
        bus.BRANCH_TARGET_EXECUTION      = '0;
    endtask

    task automatic resolve(input logic [31:0] bpc, input bit tk, input logic [31:0] tgt);
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b1;
        bus.BRANCH_RESOLVED              = 1'b1;
        bus.BRANCH_PC_EXECUTION          = bpc;
        bus.BRANCH_TAKEN_EXECUTION       = tk;
        bus.BRANCH_TARGET_EXECUTION      = tgt;
        step();
        bus.BRANCH_RESOLVED              = 1'b0;
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b0;
    endtask

    task automatic probe(input string name, input logic [31:0] addr,
                         input bit exp_tk, input logic [31:0] exp_tgt);
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b0;
        bus.PC_MISPREDICTED              = 1'b1;
        bus.REDIRECT_TARGET              = addr;
        step();
        bus.PC_MISPREDICTED              = 1'b0;
        chk({name, "_pc"}, bus.PC, addr);
        chk({name, "_taken"}, {31'b0, bus.PC_PREDICTED_TAKEN}, {31'b0, exp_tk});
        chk({name, "_target"}, bus.PC_PREDICTED_TARGET, exp_tgt);
    endtask

    typedef struct {
        logic        stall;
        logic        mis;
        logic [31:0] rt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // stall, mispredict, redirect target, expected PC after the edge
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h04});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h08});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0C});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h10});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 32'h10});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 32'h10});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 32'h10});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h14});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h18});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h1C});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h20});
        tbl.push_back('{1'b1, 1'b1, 32'h100, 32'h20});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 32'h20});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 32'h20});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h100});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h104});
        tbl.push_back('{1'b1, 1'b1, 32'h300, 32'h104});
        tbl.push_back('{1'b1, 1'b1, 32'h200, 32'h104});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h200});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h204});
        tbl.push_back('{1'b0, 1'b1, 32'h500, 32'h500});
        tbl.push_back('{1'b1, 1'b1, 32'h600, 32'h500});
        tbl.push_back('{1'b0, 1'b1, 32'h700, 32'h700});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h704});
        tbl.push_back('{1'b0, 1'b1, 32'h102, 32'h102});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h106});
        tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0});

        idle_inputs();
        RST_N = 1'b0;
        step();
        step();
        chk("reset_pc", bus.PC, 32'h0);
        chk("reset_taken", {31'b0, bus.PC_PREDICTED_TAKEN}, 32'h0);
        chk("reset_target", bus.PC_PREDICTED_TARGET, 32'h4);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            logic [31:0] exp_tgt;
            bus.STALL_PROGRAME_COUNTER_STAGE = tbl[i].stall;
            bus.PC_MISPREDICTED              = tbl[i].mis;
            bus.REDIRECT_TARGET              = tbl[i].rt;
            step();
            exp_tgt = tbl[i].exp_pc + 32'd4;
            chk($sformatf("vec%0d_pc", i), bus.PC, tbl[i].exp_pc);
            chk($sformatf("vec%0d_taken", i), {31'b0, bus.PC_PREDICTED_TAKEN}, 32'h0);
            chk($sformatf("vec%0d_target", i), bus.PC_PREDICTED_TARGET, exp_tgt);
        end
        idle_inputs();

        // BTB learning and counter saturation at 0x40
        resolve(32'h40, 1'b1, 32'h80);
        probe("learn_alloc", 32'h40, 1'b1, 32'h80);
        step();
        chk("learn_follow_pc", bus.PC, 32'h80);
        resolve(32'h40, 1'b0, 32'h999);
        probe("learn_nt1", 32'h40, 1'b0, 32'h44);
        resolve(32'h40, 1'b0, 32'h999);
        resolve(32'h40, 1'b0, 32'h999);
        probe("sat_low", 32'h40, 1'b0, 32'h44);
        resolve(32'h40, 1'b1, 32'h80);
        probe("from_sn_one_t", 32'h40, 1'b0, 32'h44);
        resolve(32'h40, 1'b1, 32'h80);
        probe("from_sn_two_t", 32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 32'h80);
        probe("sat_high", 32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b0, 32'h999);
        probe("nt_keeps_target", 32'h40, 1'b1, 32'h80);

        // Aliasing: same index, different tag
        probe("alias_miss", 32'h440, 1'b0, 32'h444);
        resolve(32'h440, 1'b0, 32'h999);
        probe("alias_nt_nochange", 32'h40, 1'b1, 32'h80);

        // Same-cycle lookup and update at one index
        bus.BRANCH_RESOLVED         = 1'b1;
        bus.BRANCH_PC_EXECUTION     = 32'h40;
        bus.BRANCH_TAKEN_EXECUTION  = 1'b1;
        bus.BRANCH_TARGET_EXECUTION = 32'hC0;
        step();
        bus.BRANCH_RESOLVED         = 1'b0;
        chk("collide_old_target", bus.PC, 32'h80);
        probe("collide_new_target", 32'h40, 1'b1, 32'hC0);

        resolve(32'h440, 1'b1, 32'h500);
        probe("alias_evicted", 32'h40, 1'b0, 32'h44);
        probe("alias_alloc", 32'h440, 1'b1, 32'h500);

        // Mid-run reset discards BTB contents and a parked redirect
        resolve(32'h4, 1'b1, 32'h80);
        probe("pre_reset_entry", 32'h4, 1'b1, 32'h80);
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b1;
        bus.PC_MISPREDICTED              = 1'b1;
        bus.REDIRECT_TARGET              = 32'h900;
        step();
        bus.PC_MISPREDICTED              = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_pc", bus.PC, 32'h0);
        chk("async_reset_taken", {31'b0, bus.PC_PREDICTED_TAKEN}, 32'h0);
        chk("async_reset_target", bus.PC_PREDICTED_TARGET, 32'h4);
        bus.STALL_PROGRAME_COUNTER_STAGE = 1'b0;
        step();
        chk("held_reset_pc", bus.PC, 32'h0);
        RST_N = 1'b1;
        step();
        chk("post_reset_pc1", bus.PC, 32'h4);
        chk("post_reset_btb_clear", {31'b0, bus.PC_PREDICTED_TAKEN}, 32'h0);
        chk("post_reset_tgt1", bus.PC_PREDICTED_TARGET, 32'h8);
        step();
        chk("post_reset_pc2", bus.PC, 32'h8);
        step();
        chk("post_reset_pc3", bus.PC, 32'hC);

        // Randomized traffic against the reference model
        RST_N = 1'b0;
        step();
        m_reset();
        RST_N = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            bit          tk;
            logic [31:0] pred;
            bus.STALL_PROGRAME_COUNTER_STAGE = ($urandom_range(0, 3) == 0);
            bus.PC_MISPREDICTED              = ($urandom_range(0, 7) == 0);
            bus.REDIRECT_TARGET              = rnd_addr();
            bus.BRANCH_RESOLVED              = ($urandom_range(0, 2) == 0);
            bus.BRANCH_PC_EXECUTION          = rnd_addr();
            bus.BRANCH_TAKEN_EXECUTION       = $urandom_range(0, 1) != 0;
            bus.BRANCH_TARGET_EXECUTION      = rnd_addr();
            m_lookup(m_pc, tk, pred);
            chk("rnd_pc", bus.PC, m_pc);
            chk("rnd_taken", {31'b0, bus.PC_PREDICTED_TAKEN}, {31'b0, tk});
            chk("rnd_target", bus.PC_PREDICTED_TARGET, pred);
            m_edge(bus.STALL_PROGRAME_COUNTER_STAGE, bus.PC_MISPREDICTED, bus.REDIRECT_TARGET,
                   bus.BRANCH_RESOLVED, bus.BRANCH_PC_EXECUTION, bus.BRANCH_TAKEN_EXECUTION,
                   bus.BRANCH_TARGET_EXECUTION);
            step();
        end
        chk("rnd_final_pc", bus.PC, m_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
